// File: rtl/variable_step_ctrl.sv
// Adaptive step-size controller: error scan, h recompute by restoring divider, output-time clipping.
// Optional build macro STEP_GROW_EN doubles h on well-converged accepts (bounded by the next time point).
module variable_step_ctrl #(
  parameter int WORD_SIZE  = 64,
  parameter int FRAC_BITS  = 32,
  parameter int ADDR_SIZE  = 10,
  parameter int RD_LATENCY = 2,
  parameter int N_ADDR     = 0,
  parameter int T_ADDR     = 1,
  parameter int H_ADDR     = 17,
  parameter int L_ADDR     = 18,
  parameter int M_ADDR     = 19,
  parameter int X0_ADDR    = 119,
  parameter int X1_ADDR    = 169,
  parameter int SAFETY_Q8  = 230,
  parameter int H_MIN      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 start_cal_err,
  output logic                 h_done,
  output logic                 error_ok,
  output logic                 sim_done,
  output logic                 busy,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(WORD_SIZE + 1);
  localparam logic [2:0]           RD_LAST = 3'(RD_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] ONE     = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] HMIN_W  = WORD_SIZE'(H_MIN);
  localparam logic [ADDR_SIZE-1:0] A_N  = ADDR_SIZE'(N_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_T  = ADDR_SIZE'(T_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_H  = ADDR_SIZE'(H_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_L  = ADDR_SIZE'(L_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_M  = ADDR_SIZE'(M_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_X0 = ADDR_SIZE'(X0_ADDR);
  localparam logic [ADDR_SIZE-1:0] A_X1 = ADDR_SIZE'(X1_ADDR);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_HDONE, S_SCAN, S_CHECK, S_DIVIDE, S_WRITE_H,
    S_TIME_CHK, S_CLIP, S_ADVANCE, S_FETCH_T, S_FINISHED
  } state_t;

  state_t               state;
  logic [WORD_SIZE-1:0] h, n, l, m, t_target, cur_time, t_idx, idx;
  logic [WORD_SIZE-1:0] max_err, x1_val, rem, dvd_lo;
  logic [WORD_SIZE-2:0] quo;
  logic [2:0]           rd_cnt, load_idx;
  logic [CW-1:0]        div_cnt;
  logic                 half, fetch_rd;

  logic                   rd_ready, fits, time_over;
  logic [WORD_SIZE-1:0]   abs_diff, q_final, h_scaled, h_new, next_time, remaining;
  logic [WORD_SIZE:0]     trial;
  logic [2*WORD_SIZE-1:0] product;

  assign h_done   = (state == S_HDONE);
  assign sim_done = (state == S_FINISHED);
  assign busy     = (state != S_IDLE) && (state != S_FINISHED);

  assign rd_ready  = (rd_cnt == RD_LAST);
  assign abs_diff  = (x1_val >= mem_rdata) ? x1_val - mem_rdata : mem_rdata - x1_val;
  assign product   = (2*WORD_SIZE)'(h) * (2*WORD_SIZE)'(l);
  // Quotient is known to be below h, so the upper product half always starts below the divisor.
  assign trial     = {rem, dvd_lo[WORD_SIZE-1]};
  assign fits      = (trial >= {1'b0, max_err});
  assign q_final   = {quo, fits};
  assign h_scaled  = WORD_SIZE'(({8'd0, q_final} * (WORD_SIZE+8)'(SAFETY_Q8)) >> 8);
  assign h_new     = (h_scaled < HMIN_W) ? HMIN_W : h_scaled;
  assign time_over = ({1'b0, cur_time} + {1'b0, h}) > {1'b0, t_target};
  assign next_time = cur_time + h;
  assign remaining = t_target - cur_time;

`ifdef STEP_GROW_EN
  logic [WORD_SIZE-1:0] grow_rem, h_grow;
  assign grow_rem = t_target - next_time;
  assign h_grow   = ({1'b0, grow_rem} < {h, 1'b0}) ? grow_rem : {h[WORD_SIZE-2:0], 1'b0};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      error_ok  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      h         <= '0;
      n         <= '0;
      l         <= '0;
      m         <= '0;
      t_target  <= '0;
      cur_time  <= '0;
      t_idx     <= '0;
      idx       <= '0;
      max_err   <= '0;
      x1_val    <= '0;
      rem       <= '0;
      dvd_lo    <= '0;
      quo       <= '0;
      rd_cnt    <= '0;
      load_idx  <= '0;
      div_cnt   <= '0;
      half      <= 1'b0;
      fetch_rd  <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      error_ok <= 1'b0;
      case (state)
        S_IDLE: if (enable) begin
          state    <= S_LOAD;
          mem_addr <= A_H;
          rd_cnt   <= '0;
          load_idx <= '0;
          cur_time <= '0;
          t_idx    <= '0;
        end
        S_LOAD: if (rd_ready) begin
          rd_cnt   <= '0;
          load_idx <= load_idx + 3'd1;
          case (load_idx)
            3'd0: begin h <= mem_rdata; mem_addr <= A_N; end
            3'd1: begin n <= mem_rdata; mem_addr <= A_L; end
            3'd2: begin l <= mem_rdata; mem_addr <= A_M; end
            3'd3: begin m <= mem_rdata; mem_addr <= A_T; end
            default: begin
              t_target <= mem_rdata;
              state    <= (m == '0) ? S_FINISHED : S_HDONE;
            end
          endcase
        end else rd_cnt <= rd_cnt + 3'd1;
        S_HDONE: if (start_cal_err) begin
          max_err  <= '0;
          idx      <= '0;
          half     <= 1'b0;
          rd_cnt   <= '0;
          mem_addr <= A_X1;
          state    <= S_SCAN;
        end
        // Each component reads X1 then X0, one RD_LATENCY window apiece.
        S_SCAN: if (n == '0) state <= S_CHECK;
        else if (rd_ready) begin
          rd_cnt <= '0;
          if (!half) begin
            x1_val   <= mem_rdata;
            mem_addr <= A_X0 + idx[ADDR_SIZE-1:0];
            half     <= 1'b1;
          end else begin
            half     <= 1'b0;
            if (abs_diff > max_err) max_err <= abs_diff;
            idx      <= idx + ONE;
            mem_addr <= A_X1 + idx[ADDR_SIZE-1:0] + ADDR_SIZE'(1);
            if (idx + ONE == n) state <= S_CHECK;
          end
        end else rd_cnt <= rd_cnt + 3'd1;
        S_CHECK: if (max_err > l) begin
          state   <= S_DIVIDE;
          div_cnt <= '0;
        end else state <= S_TIME_CHK;
        S_DIVIDE: if (div_cnt == '0) begin
          rem     <= product[2*WORD_SIZE-1:WORD_SIZE];
          dvd_lo  <= product[WORD_SIZE-1:0];
          quo     <= '0;
          div_cnt <= CW'(1);
        end else begin
          rem     <= fits ? WORD_SIZE'(trial - {1'b0, max_err}) : trial[WORD_SIZE-1:0];
          dvd_lo  <= {dvd_lo[WORD_SIZE-2:0], 1'b0};
          quo     <= q_final[WORD_SIZE-2:0];
          div_cnt <= div_cnt + CW'(1);
          if (div_cnt == CW'(WORD_SIZE)) begin
            h         <= h_new;
            mem_addr  <= A_H;
            mem_wdata <= h_new;
            mem_we    <= 1'b1;
            state     <= S_WRITE_H;
          end
        end
        S_WRITE_H: state <= S_HDONE;
        S_TIME_CHK: if (time_over) state <= S_CLIP;
        else begin
          state    <= S_ADVANCE;
          error_ok <= 1'b1;
        end
        S_CLIP: begin
          h         <= remaining;
          mem_addr  <= A_H;
          mem_wdata <= remaining;
          mem_we    <= 1'b1;
          state     <= S_WRITE_H;
        end
        S_ADVANCE: begin
          cur_time <= next_time;
          if (next_time == t_target) begin
            t_idx    <= t_idx + ONE;
            fetch_rd <= 1'b0;
            state    <= S_FETCH_T;
          end else begin
`ifdef STEP_GROW_EN
            if (max_err < (l >> 2)) begin
              h         <= h_grow;
              mem_addr  <= A_H;
              mem_wdata <= h_grow;
              mem_we    <= 1'b1;
              state     <= S_WRITE_H;
            end else state <= S_HDONE;
`else
            state <= S_HDONE;
`endif
          end
        end
        S_FETCH_T: if (!fetch_rd) begin
          if (t_idx == m) state <= S_FINISHED;
          else begin
            mem_addr <= A_T + t_idx[ADDR_SIZE-1:0];
            rd_cnt   <= '0;
            fetch_rd <= 1'b1;
          end
        end else if (rd_ready) begin
          t_target <= mem_rdata;
          fetch_rd <= 1'b0;
          state    <= S_HDONE;
        end else rd_cnt <= rd_cnt + 3'd1;
        S_FINISHED: state <= S_FINISHED;
        default:    state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_variable_step_ctrl.sv
// Directed bench for variable_step_ctrl: RAM model with two-cycle read latency and hand-computed steps.
module tb_variable_step_ctrl;

  localparam int RD_LAT = 2;
  localparam int NCOMP  = 3;
  localparam logic [63:0] ONE_P0 = 64'h1_0000_0000;
`ifdef STEP_GROW_EN
  localparam int GROW = 1;
`else
  localparam int GROW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic        start_cal_err = 1'b0;
  logic        h_done, error_ok, sim_done, busy, mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  logic [63:0] mem [0:1023];
  logic [63:0] rd_q;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [63:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int ok_n, wr_n, ok_at, we_at, cyc;
  bit stopped;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;

  int exp_ok  [6] = '{1, 1, 0, 1, 1, 1};
  int exp_wr  [6] = '{0, 0, 1, 0, 0, 0};
  int exp_sim [6] = '{0, 0, 0, 0, 0, 1};
  int exp_addr [10] = '{17, 17, 0, 0, 18, 18, 19, 19, 1, 1};

  variable_step_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start_cal_err(start_cal_err),
    .h_done(h_done), .error_ok(error_ok), .sim_done(sim_done), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // One register stage: data for an address is sampleable two edges after the DUT drives it.
  always @(posedge clk) begin
    rd_q <= mem[mem_addr];
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeRam(input int addr, input logic [63:0] data);
    pre_addr = 10'(addr);
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic resetDut();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic startRun();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    cyc = 0;
    while (!h_done && !sim_done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  // Pulse start_cal_err and follow the DUT until h_done or sim_done returns.
  task automatic applyStimulus(input bit stop_on_we);
    ok_n = 0; wr_n = 0; ok_at = -1; we_at = -1; stopped = 1'b0;
    wr_addr = '0; wr_data = '0;
    start_cal_err = 1'b1;
    tick();
    start_cal_err = 1'b0;
    cyc = 0;
    while (!h_done && !sim_done && !stopped && cyc < 300) begin
      tick();
      cyc++;
      if (error_ok) begin
        ok_n++;
        if (ok_at < 0) ok_at = cyc;
      end
      if (mem_we) begin
        wr_n++;
        if (we_at < 0) we_at = cyc;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        if (stop_on_we) stopped = 1'b1;
      end
    end
    checkOutput("step_completes", 64'(h_done | sim_done | stopped), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_h_done", 64'(h_done), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_sim_done", 64'(sim_done), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_error_ok", 64'(error_ok), 64'd0);

    writeRam(17, ONE_P0);
    writeRam(0, 64'd3);
    writeRam(18, 64'h0100_0000);
    writeRam(19, 64'd2);
    writeRam(1, 64'h4_0000_0000);
    writeRam(2, 64'h6_0000_0000);
    writeRam(119, 64'h20);  writeRam(120, 64'h1000_0000); writeRam(121, 64'h0);
    writeRam(169, 64'h10);  writeRam(170, 64'h10FF_0000); writeRam(171, 64'h20);
    reset_n = 1'b1;
    tick();

    // Load sequence: each address held for exactly RD_LAT cycles.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checkOutput("load_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      checkOutput($sformatf("load_addr_%0d", k), 64'(mem_addr), 64'(exp_addr[k]));
    end
    checkOutput("load_h_done_early", 64'(h_done), 64'd0);
    tick();
    checkOutput("load_h_done", 64'(h_done), 64'd1);

    // Accept: max diff 0x00FF_0000 is within L.
    applyStimulus(1'b0);
    checkOutput("acc_ok_count", 64'(ok_n), 64'd1);
    checkOutput("acc_ok_cycle", 64'(ok_at), 64'(2*RD_LAT*NCOMP + 2));
    checkOutput("acc_writes", 64'(wr_n), 64'd0);
    checkOutput("acc_h_done", 64'(h_done), 64'd1);

    // Reject: diff 0x0400_0000 gives q=0x4000_0000, h_new=0x3980_0000.
    writeRam(170, 64'h1400_0000);
    applyStimulus(1'b0);
    checkOutput("rej_ok_count", 64'(ok_n), 64'd0);
    checkOutput("rej_writes", 64'(wr_n), 64'd1);
    checkOutput("rej_wr_addr", 64'(wr_addr), 64'd17);
    checkOutput("rej_wr_data", wr_data, 64'h3980_0000);
    checkOutput("rej_we_cycle", 64'(we_at), 64'(2*RD_LAT*NCOMP + 1 + 65));

    // Second reject from h=0x3980_0000 gives 0x0CEA_4000; reset lands mid-write.
    applyStimulus(1'b1);
    checkOutput("rej2_we_cycle", 64'(we_at), 64'(2*RD_LAT*NCOMP + 1 + 65));
    checkOutput("rej2_wr_data", 64'(mem_wdata), 64'h0CEA_4000);
    checkOutput("rej2_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_mem_we", 64'(mem_we), 64'd0);
    checkOutput("async_h_done", 64'(h_done), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    tick();
    reset_n = 1'b1;
    start_cal_err = 1'b1;
    tick(); tick(); tick();
    start_cal_err = 1'b0;
    checkOutput("idle_ignore_h_done", 64'(h_done), 64'd0);
    checkOutput("idle_ignore_busy", 64'(busy), 64'd0);
    checkOutput("idle_ignore_we", 64'(mem_we), 64'd0);

    // Clip/time-point walk: h=1.5, T={4,6}, max diff exactly L.
    writeRam(17, 64'h1_8000_0000);
    writeRam(169, 64'h0100_0000); writeRam(170, 64'h5); writeRam(171, 64'h0);
    writeRam(119, 64'h0);         writeRam(120, 64'h0); writeRam(121, 64'h0);
    startRun();
    checkOutput("run2_h_done", 64'(h_done), 64'd1);
    for (int s = 0; s < 6; s++) begin
      applyStimulus(1'b0);
      checkOutput($sformatf("run2_ok_%0d", s), 64'(ok_n), 64'(exp_ok[s]));
      checkOutput($sformatf("run2_wr_%0d", s), 64'(wr_n), 64'(exp_wr[s]));
      checkOutput($sformatf("run2_sim_%0d", s), 64'(sim_done), 64'(exp_sim[s]));
      if (exp_wr[s] == 1) checkOutput("run2_clip_h", wr_data, ONE_P0);
    end
    checkOutput("fin_busy", 64'(busy), 64'd0);
    checkOutput("fin_h_done", 64'(h_done), 64'd0);
    start_cal_err = 1'b1;
    tick();
    start_cal_err = 1'b0;
    tick();
    checkOutput("fin_sticky", 64'(sim_done), 64'd1);
    checkOutput("fin_no_ok", 64'(error_ok), 64'd0);

    // N=0 with zero error: h=0.5, remaining 2.0 after first accept.
    writeRam(17, 64'h8000_0000);
    writeRam(0, 64'd0);
    writeRam(19, 64'd1);
    writeRam(1, 64'h2_8000_0000);
    resetDut();
    startRun();
    applyStimulus(1'b0);
    checkOutput("n0_ok_cycle", 64'(ok_at), 64'd3);
    checkOutput("n0_ok_count", 64'(ok_n), 64'd1);
    checkOutput("grow_writes", 64'(wr_n), 64'(GROW));
    if (GROW == 1) checkOutput("grow_h", wr_data, ONE_P0);
    applyStimulus(1'b0);
    checkOutput("grow2_ok", 64'(ok_n), 64'd1);
    checkOutput("grow2_writes", 64'(wr_n), 64'(GROW));

    // M=0 finishes straight after the load.
    writeRam(19, 64'd0);
    resetDut();
    startRun();
    checkOutput("m0_sim_done", 64'(sim_done), 64'd1);
    checkOutput("m0_h_done", 64'(h_done), 64'd0);
    checkOutput("m0_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
